// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM capture block and its generator counterpart.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_e;

   localparam int unsigned CNT_W_DEF   = 9;
   localparam int unsigned TIMEOUT_DEF = 511;
   localparam int unsigned GEN_PERIOD  = 256;

endpackage

// File: rtl/pwm_duty_capture_if.sv
// PWM input and measurement results; master drives pwm_in, slave is the capture block.
interface pwm_duty_capture_if #(
   parameter int unsigned CNT_W = pwm_pkg::CNT_W_DEF
);
   logic             pwm_in;
   logic [CNT_W-1:0] duty_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic             valid;
   logic             stuck_low;
   logic             stuck_high;

   modport master (
      output pwm_in,
      input  duty_cnt, period_cnt, valid, stuck_low, stuck_high
   );

   modport slave (
      input  pwm_in,
      output duty_cnt, period_cnt, valid, stuck_low, stuck_high
   );
endinterface

// File: rtl/pwm_in_sync.sv
// Multi-flop synchronizer for the asynchronous PWM input followed by a rise/fall detector.
module pwm_in_sync #(
   parameter int unsigned SYNC_STAGES = 2  // at least 2
) (
   input  logic clk,
   input  logic reset,
   input  logic pwm_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign lvl_o  = sync_q[SYNC_STAGES-1];
   assign rise_o =  lvl_o & ~prev_q;
   assign fall_o = ~lvl_o &  prev_q;
endmodule

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of each complete PWM cycle and flags stuck-low/high inputs.
module pwm_duty_capture
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W       = CNT_W_DEF,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   pwm_duty_capture_if.slave   bus
);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TIMEOUT_PRE = CNT_W'(TIMEOUT - 1);

   logic lvl, rise, fall;

   pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_i  (bus.pwm_in),
      .lvl_o  (lvl),
      .rise_o (rise),
      .fall_o (fall)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             stuck_low_q, stuck_low_d;
   logic             stuck_high_q, stuck_high_d;

   logic             any_edge;
   logic             timeout_hit;
   logic [CNT_W:0]   sum_w;

   assign any_edge    = rise | fall;
   // The flags fire on the single cycle where idle_cnt steps onto TIMEOUT.
   assign timeout_hit = ~any_edge & (idle_q == TIMEOUT_PRE);
   assign sum_w       = {1'b0, hi_q} + {1'b0, lo_q};

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      idle_d       = idle_q;
      duty_d       = duty_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      stuck_low_d  = stuck_low_q;
      stuck_high_d = stuck_high_q;

      if (any_edge) begin
         idle_d       = '0;
         stuck_low_d  = 1'b0;
         stuck_high_d = 1'b0;
      end else if (idle_q != TIMEOUT_C) begin
         idle_d = idle_q + CNT_ONE;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_HIGH;
               hi_d    = CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_d = ST_LOW;
               lo_d    = CNT_ONE;
            end else if (hi_q != CNT_MAX) begin
               hi_d = hi_q + CNT_ONE;
            end
         end
         ST_LOW: begin
            if (rise) begin
               duty_d   = hi_q;
               period_d = sum_w[CNT_W] ? CNT_MAX : sum_w[CNT_W-1:0];
               valid_d  = 1'b1;
               hi_d     = CNT_ONE;
               state_d  = ST_HIGH;
            end else if (lo_q != CNT_MAX) begin
               lo_d = lo_q + CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (timeout_hit) begin
         state_d      = ST_IDLE;
         stuck_low_d  = ~lvl;
         stuck_high_d =  lvl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hi_q         <= '0;
         lo_q         <= '0;
         idle_q       <= '0;
         duty_q       <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         stuck_low_q  <= 1'b0;
         stuck_high_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         idle_q       <= idle_d;
         duty_q       <= duty_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         stuck_low_q  <= stuck_low_d;
         stuck_high_q <= stuck_high_d;
      end
   end

   assign bus.duty_cnt   = duty_q;
   assign bus.period_cnt = period_q;
   assign bus.valid      = valid_q;
   assign bus.stuck_low  = stuck_low_q;
   assign bus.stuck_high = stuck_high_q;
endmodule
